// File: rtl/mips_core.sv
// MIPS32 single-cycle core: fetch, decode, execute, memory and
// write-back all complete within one clock; memories are internal.
module mips_core #(
  parameter int          DATA_MEM_DEPTH = 256,
  parameter int          IMEM_DEPTH     = 512,
  parameter logic [31:0] RESET_PC       = 32'h00400000
) (
  input  logic clk,
  input  logic rst
);

  localparam int DAW = $clog2(DATA_MEM_DEPTH);
  localparam int IAW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [31:0]    r_pc;
  logic [31:0]    w_pc_plus4;
  logic [31:0]    w_pc_next;
  logic [31:0]    w_ioff;
  logic [IAW-1:0] w_iidx;
  logic [31:0]    w_instr;

  logic [5:0]     w_op;
  logic [4:0]     w_rs;
  logic [4:0]     w_rt;
  logic [4:0]     w_rd;
  logic [4:0]     w_shamt;
  logic [5:0]     w_funct;
  logic [15:0]    w_imm;
  logic [25:0]    w_target;
  logic [31:0]    w_sext;
  logic [31:0]    w_zext;

  logic [31:0]    w_rs_data;
  logic [31:0]    w_rt_data;
  logic [31:0]    w_r_res;
  logic           w_r_ok;
  logic           w_r_jr;

  logic [31:0]    w_br_target;
  logic [31:0]    w_jmp_target;
  logic [31:0]    w_mem_addr;
  logic [DAW-1:0] w_dm_idx;
  logic [31:0]    w_dm_rdata;

  logic           w_rf_we;
  logic [4:0]     w_rf_waddr;
  logic [31:0]    w_rf_wdata;
  logic           w_dm_we;
  logic           w_rf_commit;
  logic           w_dm_commit;

  logic           w_iload_we;
  logic [IAW-1:0] w_iload_idx;
  logic [31:0]    w_iload_data;
  logic           w_unused;

  // Loader port is idle: the program image is placed by hierarchy.
  assign w_iload_we   = 1'b0;
  assign w_iload_idx  = '0;
  assign w_iload_data = '0;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ioff     = (r_pc - RESET_PC) >> 2;
  assign w_iidx     = IAW'(w_ioff % IMEM_DEPTH);

  if (1'b1) begin : InstructionMemory
    logic [31:0] regData [IMEM_DEPTH];
    always_ff @(posedge clk) begin
      if (w_iload_we) regData[w_iload_idx] <= w_iload_data;
    end
    assign w_instr = regData[w_iidx];
  end

  assign w_op     = w_instr[31:26];
  assign w_rs     = w_instr[25:21];
  assign w_rt     = w_instr[20:16];
  assign w_rd     = w_instr[15:11];
  assign w_shamt  = w_instr[10:6];
  assign w_funct  = w_instr[5:0];
  assign w_imm    = w_instr[15:0];
  assign w_target = w_instr[25:0];
  assign w_sext   = {{16{w_imm[15]}}, w_imm};
  assign w_zext   = {16'h0000, w_imm};

  // Writes are dropped while reset is held, aborting the current op.
  assign w_rf_commit = w_rf_we & rst;
  assign w_dm_commit = w_dm_we & rst;

  if (1'b1) begin : RegBank
    logic [31:0] reg_file_ff [32];
    always_ff @(posedge clk) begin
      if (w_rf_commit && (w_rf_waddr != 5'd0))
        reg_file_ff[w_rf_waddr] <= w_rf_wdata;
    end
    assign w_rs_data = (w_rs == 5'd0) ? '0 : reg_file_ff[w_rs];
    assign w_rt_data = (w_rt == 5'd0) ? '0 : reg_file_ff[w_rt];
  end

  assign w_mem_addr = w_rs_data + w_sext;
  assign w_dm_idx   = w_mem_addr[DAW+1:2];

  if (1'b1) begin : DataMemory
    logic [31:0] data_mem_ff [DATA_MEM_DEPTH];
    always_ff @(posedge clk) begin
      if (w_dm_commit) data_mem_ff[w_dm_idx] <= w_rt_data;
    end
    assign w_dm_rdata = data_mem_ff[w_dm_idx];
  end

  assign w_br_target  = w_pc_plus4 + {w_sext[29:0], 2'b00};
  assign w_jmp_target = {w_pc_plus4[31:28], w_target, 2'b00};

  always_comb begin
    w_r_res = '0;
    w_r_ok  = 1'b1;
    w_r_jr  = 1'b0;
    case (w_funct)
      FN_ADD,
      FN_ADDU: w_r_res = w_rs_data + w_rt_data;
      FN_SUB,
      FN_SUBU: w_r_res = w_rs_data - w_rt_data;
      FN_AND:  w_r_res = w_rs_data & w_rt_data;
      FN_OR:   w_r_res = w_rs_data | w_rt_data;
      FN_XOR:  w_r_res = w_rs_data ^ w_rt_data;
      FN_NOR:  w_r_res = ~(w_rs_data | w_rt_data);
      FN_SLT:
        w_r_res = {31'd0,
                   $signed(w_rs_data) < $signed(w_rt_data)};
      FN_SLTU:
        w_r_res = {31'd0, w_rs_data < w_rt_data};
      FN_SLL:  w_r_res = w_rt_data << w_shamt;
      FN_SRL:  w_r_res = w_rt_data >> w_shamt;
      FN_SRA:  w_r_res = $signed(w_rt_data) >>> w_shamt;
      FN_JR: begin
        w_r_ok = 1'b0;
        w_r_jr = 1'b1;
      end
      default: w_r_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = '0;
    w_dm_we    = 1'b0;
    w_pc_next  = w_pc_plus4;
    case (w_op)
      OP_RTYPE: begin
        w_rf_we    = w_r_ok;
        w_rf_waddr = w_rd;
        w_rf_wdata = w_r_res;
        if (w_r_jr) w_pc_next = w_rs_data;
      end
      OP_ADDI,
      OP_ADDIU: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_data + w_sext;
      end
      OP_SLTI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {31'd0,
                      $signed(w_rs_data) < $signed(w_sext)};
      end
      OP_ANDI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_data & w_zext;
      end
      OP_ORI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_data | w_zext;
      end
      OP_XORI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_rs_data ^ w_zext;
      end
      OP_LUI: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = {w_imm, 16'h0000};
      end
      OP_LW: begin
        w_rf_we    = 1'b1;
        w_rf_wdata = w_dm_rdata;
      end
      OP_SW: w_dm_we = 1'b1;
      OP_BEQ: begin
        if (w_rs_data == w_rt_data) w_pc_next = w_br_target;
      end
      OP_BNE: begin
        if (w_rs_data != w_rt_data) w_pc_next = w_br_target;
      end
      OP_J: w_pc_next = w_jmp_target;
      OP_JAL: begin
        w_pc_next  = w_jmp_target;
        w_rf_we    = 1'b1;
        w_rf_waddr = 5'd31;
        w_rf_wdata = w_pc_plus4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= RESET_PC;
    else      r_pc <= w_pc_next;
  end

  assign w_unused = &{1'b0, w_mem_addr[31:DAW+2],
                      w_mem_addr[1:0]};

endmodule

// File: tb/tb_mips_core.sv
// Randomised and directed bench for mips_core: an instruction-level
// interpreter predicts PC and architectural state for every retired op.
module tb_mips_core;

  localparam int          IMD = 512;
  localparam int          DMD = 256;
  localparam logic [31:0] RPC = 32'h00400000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mips_core #(
    .DATA_MEM_DEPTH(DMD),
    .IMEM_DEPTH    (IMD),
    .RESET_PC      (RPC)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rs;
    logic [31:0] ms;
  } exp_t;

  exp_t        q[$];
  logic [31:0] pc_hist[$];
  logic [31:0] m_im [IMD];
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DMD];
  logic [31:0] m_pc;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mix(logic [31:0] s, logic [31:0] v,
                                      int i);
    return {s[30:0], s[31]} ^ (v + 32'(i) * 32'h9E3779B9);
  endfunction

  function automatic logic [31:0] m_rsig();
    logic [31:0] s = '0;
    for (int i = 0; i < 32; i++) s = mix(s, m_rf[i], i);
    return s;
  endfunction

  function automatic logic [31:0] m_msig();
    logic [31:0] s = '0;
    for (int i = 0; i < DMD; i++) s = mix(s, m_dm[i], i);
    return s;
  endfunction

  function automatic logic [31:0] d_rsig();
    logic [31:0] s = '0;
    for (int i = 0; i < 32; i++)
      s = mix(s, dut.RegBank.reg_file_ff[i], i);
    return s;
  endfunction

  function automatic logic [31:0] d_msig();
    logic [31:0] s = '0;
    for (int i = 0; i < DMD; i++)
      s = mix(s, dut.DataMemory.data_mem_ff[i], i);
    return s;
  endfunction

  task automatic setw(int i, logic [31:0] w);
    m_im[i] = w;
    dut.InstructionMemory.regData[i] = w;
  endtask

  task automatic setr(int i, logic [31:0] v);
    m_rf[i] = v;
    dut.RegBank.reg_file_ff[i] = v;
  endtask

  task automatic setm(int i, logic [31:0] v);
    m_dm[i] = v;
    dut.DataMemory.data_mem_ff[i] = v;
  endtask

  task automatic clear_all();
    for (int i = 0; i < IMD; i++) setw(i, 32'h0);
    for (int i = 0; i < 32; i++) setr(i, 32'h0);
    for (int i = 0; i < DMD; i++) setm(i, 32'h0);
  endtask

  // Instruction-level interpreter of the MIPS subset.
  function automatic void model_step();
    logic [31:0] ins, a, b, se, res, np, ea, p2;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh;
    int          dst;
    bit          wr;
    ins = m_im[((m_pc - RPC) >> 2) % IMD];
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    sh  = ins[10:6];
    fn  = ins[5:0];
    a   = m_rf[rs];
    b   = m_rf[rt];
    se  = {{16{ins[15]}}, ins[15:0]};
    ea  = a + se;
    np  = m_pc + 4;
    p2  = 32'd1 << sh;
    wr  = 0;
    dst = rt;
    res = 0;
    case (op)
      6'h00: begin
        dst = rd;
        wr  = 1;
        case (fn)
          6'h20, 6'h21: res = a + b;
          6'h22, 6'h23: res = a - b;
          6'h24: res = a & b;
          6'h25: res = a | b;
          6'h26: res = a ^ b;
          6'h27: res = ~(a | b);
          6'h2A: res = ($signed(a) < $signed(b)) ? 1 : 0;
          6'h2B: res = (a < b) ? 1 : 0;
          6'h00: res = b * p2;
          6'h02: res = b / p2;
          6'h03: res = (b / p2) | (b[31] ? ~(32'hFFFFFFFF / p2) : 0);
          6'h08: begin
            wr = 0;
            np = a;
          end
          default: wr = 0;
        endcase
      end
      6'h08, 6'h09: begin wr = 1; res = a + se; end
      6'h0A: begin wr = 1; res = ($signed(a) < $signed(se)) ? 1 : 0; end
      6'h0C: begin wr = 1; res = a & {16'h0, ins[15:0]}; end
      6'h0D: begin wr = 1; res = a | {16'h0, ins[15:0]}; end
      6'h0E: begin wr = 1; res = a ^ {16'h0, ins[15:0]}; end
      6'h0F: begin wr = 1; res = ins[15:0] * 65536; end
      6'h23: begin wr = 1; res = m_dm[(ea >> 2) % DMD]; end
      6'h2B: m_dm[(ea >> 2) % DMD] = b;
      6'h04: if (a == b) np = m_pc + 4 + se * 4;
      6'h05: if (a != b) np = m_pc + 4 + se * 4;
      6'h02: np = ((m_pc + 4) & 32'hF0000000) | (ins[25:0] * 4);
      6'h03: begin
        np  = ((m_pc + 4) & 32'hF0000000) | (ins[25:0] * 4);
        wr  = 1;
        dst = 31;
        res = m_pc + 4;
      end
      default: ;
    endcase
    if (wr && dst != 0) m_rf[dst] = res;
    m_pc = np;
  endfunction

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen();
    logic [4:0]  rs = rreg();
    logic [4:0]  rt = rreg();
    logic [4:0]  rd = rreg();
    logic [4:0]  sh = 5'($urandom_range(0, 31));
    logic [15:0] im = 16'($urandom);
    logic [5:0]  c  = '0;
    int          k  = $urandom_range(0, 29);
    if (k < 15) begin
      case (k)
        0: c = 6'h20;  1: c = 6'h21;  2: c = 6'h22;  3: c = 6'h23;
        4: c = 6'h24;  5: c = 6'h25;  6: c = 6'h26;  7: c = 6'h27;
        8: c = 6'h2A;  9: c = 6'h2B; 10: c = 6'h00; 11: c = 6'h02;
        12: c = 6'h03; 13: c = 6'h08;
        default: c = 6'h3F;
      endcase
      return {6'h00, rs, rt, rd, sh, c};
    end
    case (k - 15)
      0: c = 6'h08;  1: c = 6'h09;  2: c = 6'h0A;  3: c = 6'h0C;
      4: c = 6'h0D;  5: c = 6'h0E;  6: c = 6'h0F;  7: c = 6'h23;
      8: c = 6'h2B;  9: c = 6'h04; 10: c = 6'h05; 11: c = 6'h02;
      12: c = 6'h03; 13: c = 6'h3E;
      default: return 32'h0;
    endcase
    if (c == 6'h02 || c == 6'h03) return {c, 26'($urandom)};
    return {c, rs, rt, im};
  endfunction

  // Monitor: one retired instruction per falling edge while running.
  always @(negedge clk) begin
    exp_t e;
    if (rst && q.size() > 0) begin
      e = q.pop_front();
      pc_hist.push_back(dut.r_pc);
      chk("step_pc", dut.r_pc, e.pc);
      chk("step_regs", d_rsig(), e.rs);
      chk("step_dmem", d_msig(), e.ms);
    end
  end

  task automatic run_prog(int n);
    exp_t e;
    bit   done = 0;
    m_pc = RPC;
    pc_hist.delete();
    for (int i = 0; i < n; i++) begin
      model_step();
      e.pc = m_pc;
      e.rs = m_rsig();
      e.ms = m_msig();
      q.push_back(e);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    for (int c = 0; c < n + 20 && !done; c++) begin
      @(negedge clk);
      #2;
      if (q.size() == 0) done = 1;
    end
    rst = 1'b0;
    if (!done) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
    #1;
    chk("rst_pc", dut.r_pc, RPC);
    chk("rst_regs", d_rsig(), m_rsig());
    repeat (3) @(posedge clk);
    #1;
    chk("hold_pc", dut.r_pc, RPC);
    chk("hold_regs", d_rsig(), m_rsig());
    chk("hold_dmem", d_msig(), m_msig());
  endtask

  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("reset_pc", dut.r_pc, RPC);

    clear_all();
    setw(0, 32'h00000000); setw(1, 32'h20010001);
    setw(2, 32'h200f000f); setw(3, 32'h08100009);
    setw(4, 32'h10010003); setw(5, 32'h10210002);
    setw(6, 32'h00000000); setw(7, 32'h00000000);
    setw(8, 32'h22310001); setw(9, 32'h08100007);
    setw(10, 32'h00211020);
    setr(31, 32'h10010000);
    run_prog(19);
    chk("loop_r1", dut.RegBank.reg_file_ff[1], 32'd1);
    chk("loop_r15", dut.RegBank.reg_file_ff[15], 32'd15);
    chk("loop_r17", dut.RegBank.reg_file_ff[17], 32'd5);
    chk("loop_r31", dut.RegBank.reg_file_ff[31], 32'h10010000);
    chk("loop_r2", dut.RegBank.reg_file_ff[2], 32'd0);
    chk("loop_pc3", pc_hist[3], 32'h00400024);
    chk("loop_pc18", pc_hist[18], 32'h00400024);

    clear_all();
    setw(0, 32'h34081234); setw(1, 32'hAC080004);
    setw(2, 32'h8C090004);
    run_prog(3);
    chk("sw_mem1", dut.DataMemory.data_mem_ff[1], 32'h1234);
    chk("lw_r9", dut.RegBank.reg_file_ff[9], 32'h1234);

    clear_all();
    setw(0, 32'h2001FFFF); setw(1, 32'h0001102B);
    setw(2, 32'h0001182A); setw(3, 32'h00012702);
    setw(4, 32'h00012903);
    run_prog(5);
    chk("sltu_r2", dut.RegBank.reg_file_ff[2], 32'd1);
    chk("slt_r3", dut.RegBank.reg_file_ff[3], 32'd0);
    chk("srl_r4", dut.RegBank.reg_file_ff[4], 32'hF);
    chk("sra_r5", dut.RegBank.reg_file_ff[5], 32'hFFFFFFFF);

    clear_all();
    setw(0, 32'h10000002); setw(3, 32'h14000002);
    run_prog(2);
    chk("beq_pc", pc_hist[0], 32'h0040000C);
    chk("bne_pc", pc_hist[1], 32'h00400010);

    clear_all();
    setw(2, 32'h0C100010); setw(16, 32'h03E00008);
    setw(3, 32'h20000005);
    run_prog(5);
    chk("jal_pc", pc_hist[2], 32'h00400040);
    chk("jr_pc", pc_hist[3], 32'h0040000C);
    chk("jal_r31", dut.RegBank.reg_file_ff[31], 32'h0040000C);
    chk("r0_zero", dut.RegBank.reg_file_ff[0], 32'd0);

    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < IMD; i++) setw(i, gen());
      setr(0, 32'h0);
      for (int i = 1; i < 32; i++) setr(i, $urandom);
      for (int i = 0; i < DMD; i++) setm(i, $urandom);
      run_prog(150);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 Parameter DATA_MEM_DEPTH, default 256, data memory depth in 32-bit words (power of 2).
REQ-002 Parameter IMEM_DEPTH, default 512, instruction memory depth in 32-bit words.
REQ-003 Parameter RESET_PC, default 32'h00400000, PC value after reset and base address of instruction memory.
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-low.
REQ-006 No other ports; memories and register file are internal and reachable by hierarchical name.
REQ-007 Internal instances SHALL be named InstructionMemory (array regData[IMEM_DEPTH] of 32 bits), RegBank (array reg_file_ff[32] of 32 bits), DataMemory (array data_mem_ff[DATA_MEM_DEPTH] of 32 bits), writable by a bench.

Function
REQ-008 Single-cycle, non-pipelined MIPS32 subset; one instruction retires per clk; no branch/jump delay slot.
REQ-009 Fetch: combinational read regData[(PC-RESET_PC)>>2], index wrapped modulo IMEM_DEPTH.
REQ-010 Register file: 2 combinational read ports, 1 synchronous write port; $0 reads 0 always, writes to $0 ignored.
REQ-011 R-type (op 0) by funct: add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A (signed), sltu 0x2B, sll 0x00, srl 0x02, sra 0x03 (shamt), jr 0x08; write rd.
REQ-012 I-type: addi 0x08, addiu 0x09, slti 0x0A (sign-extended imm); andi 0x0C, ori 0x0D, xori 0x0E (zero-extended imm); lui 0x0F (imm<<16); write rt.
REQ-013 Arithmetic wraps mod 2^32; no overflow exceptions.
REQ-014 lw 0x23 / sw 0x2B: address = rs + sext(imm); word index = address[log2(DATA_MEM_DEPTH)+1:2]; lw combinational read into rt; sw writes on clk edge.
REQ-015 beq 0x04 / bne 0x05: if taken, PC <= PC+4+(sext(imm)<<2), else PC+4.
REQ-016 j 0x02: PC <= {PC+4[31:28], target, 2'b00}; jal 0x03: same and $31 <= PC+4.
REQ-017 jr: PC <= rs.
REQ-018 Encoding 32'h00000000 (sll $0,$0,0) is a NOP.
REQ-019 Unsupported opcodes/functs behave as NOP: no register/memory write, PC <= PC+4.
REQ-020 Misaligned addresses: low 2 bits ignored.

Reset
REQ-021 While rst low, PC SHALL be RESET_PC (asynchronously forced), and no register-file or data-memory writes SHALL occur.
REQ-022 Reset SHALL NOT clear regData, reg_file_ff or data_mem_ff; contents written during reset persist.
REQ-023 First rising clk after rst rises executes instruction at RESET_PC; reset asserted mid-run aborts the current instruction's writes and returns PC to RESET_PC.

Verification
REQ-024 Program at index 0..10: 0, 20010001, 200f000f, 08100009, 10010003, 10210002, 0, 0, 22310001, 08100007, 00211020; $31 preloaded 10010000 in reset -> $1=1, $15=15, index 4/5/10 never executed, PC cycles 0x0040001C/20/24, $17 +1 every 3 cycles, $31 stays 10010000, $2 stays 0.
REQ-025 ori $8,$0,0x1234; sw $8,4($0); lw $9,4($0) -> data_mem_ff[1]=0x1234, $9=0x1234.
REQ-026 addi $1,$0,-1; sltu $2,$0,$1; slt $3,$0,$1; srl $4,$1,28; sra $5,$1,4 -> $2=1, $3=0, $4=0xF, $5=0xFFFFFFFF.
REQ-027 beq $0,$0,+2 at 0x00400000 -> next PC 0x0040000C; bne $0,$0,+2 -> 0x00400004.
REQ-028 jal to 0x00400040 at PC 0x00400008, then jr $31 -> $31=0x0040000C, PC returns to 0x0040000C; addi $0,$0,5 -> $0 reads 0.
REQ-029 Assert rst low mid-program -> PC=0x00400000 immediately, register contents unchanged.
